// File: rtl/deserializer_8way.sv
// Serial-to-parallel receiver. Bits arrive under a valid/ready handshake and are
// packed into WIDTH-bit words, which are held in a one-entry buffer with a registered OR flag.
module deserializer_8way #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_any
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    function automatic logic or_reduce(input logic [WIDTH-1:0] v);
        or_reduce = |v;
    endfunction

    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             any_q, any_d;

    logic [WIDTH-1:0] shifted_s;
    logic             last_s;
    logic             in_ready_s;
    logic             xfer_s;
    logic             complete_s;

    // Handshake decode: only the word-completing bit can be stalled by a full buffer.
    always_comb begin
        shifted_s = sreg_q;
        if (MSB_FIRST) begin
            shifted_s = {sreg_q[WIDTH-2:0], in_bit};
        end else begin
            shifted_s = {in_bit, sreg_q[WIDTH-1:1]};
        end
        last_s     = (count_q == LAST);
        in_ready_s = !(last_s && valid_q && !out_ready);
        xfer_s     = in_valid && in_ready_s;
        complete_s = xfer_s && last_s;
    end

    // Next-state for shifter, counter and output buffer.
    always_comb begin
        sreg_d  = sreg_q;
        count_d = count_q;
        data_d  = data_q;
        valid_d = valid_q;
        any_d   = any_q;
        if (xfer_s) begin
            sreg_d = shifted_s;
            if (last_s) begin
                count_d = {CW{1'b0}};
            end else begin
                count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
            end
        end else begin
            sreg_d  = sreg_q;
            count_d = count_q;
        end
        // A completion on the same edge as a consume refills the buffer without a bubble.
        if (complete_s) begin
            data_d  = shifted_s;
            any_d   = or_reduce(shifted_s);
            valid_d = 1'b1;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sreg_q  <= {WIDTH{1'b0}};
            count_q <= {CW{1'b0}};
            data_q  <= {WIDTH{1'b0}};
            valid_q <= 1'b0;
            any_q   <= 1'b0;
        end else begin
            sreg_q  <= sreg_d;
            count_q <= count_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            any_q   <= any_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_any   = any_q;

endmodule

// File: tb/tb_deserializer_8way.sv
// Bench for deserializer_8way: an MSB-first and an LSB-first instance share one stimulus
// stream; a queue-based reference model predicts words and a monitor scores each consumed word.
module tb_deserializer_8way;

    logic clk = 1'b0;
    logic reset;
    logic in_bit;
    logic in_valid;
    logic out_ready;

    logic       rdy0, vld0, any0, rdy1, vld1, any1;
    logic [7:0] dat0, dat1;

    int n_checks = 0;
    int n_errors = 0;

    logic [8:0] expq0[$];
    logic [8:0] expq1[$];
    int         cnt_m[2];
    logic       full_m[2];
    logic       bits_m[2][8];

    always #5 clk = ~clk;

    deserializer_8way #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset), .in_bit(in_bit), .in_valid(in_valid), .in_ready(rdy0),
        .out_data(dat0), .out_valid(vld0), .out_ready(out_ready), .out_any(any0)
    );

    deserializer_8way #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .in_bit(in_bit), .in_valid(in_valid), .in_ready(rdy1),
        .out_data(dat1), .out_valid(vld1), .out_ready(out_ready), .out_any(any1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: bits are collected in arrival order and packed by the bit-order rule.
    task automatic model_step(input int k, input logic rdy, input logic vld);
        logic       exp_rdy;
        logic       consume;
        logic [7:0] w;
        if (reset) begin
            cnt_m[k]  = 0;
            full_m[k] = 1'b0;
            if (k == 0) expq0.delete(); else expq1.delete();
            return;
        end
        exp_rdy = !(cnt_m[k] == 7 && full_m[k] && !out_ready);
        check((k == 0) ? "in_ready_msb" : "in_ready_lsb", {31'd0, rdy}, {31'd0, exp_rdy});
        check((k == 0) ? "out_valid_msb" : "out_valid_lsb", {31'd0, vld}, {31'd0, full_m[k]});
        consume = full_m[k] && out_ready;
        if (in_valid && exp_rdy) begin
            bits_m[k][cnt_m[k]] = in_bit;
            cnt_m[k]++;
        end
        if (in_valid && exp_rdy && cnt_m[k] == 8) begin
            w = 8'h00;
            for (int i = 0; i < 8; i++) begin
                if (k == 0) w[7-i] = bits_m[k][i];
                else        w[i]   = bits_m[k][i];
            end
            if (k == 0) expq0.push_back({(w != 8'h00), w});
            else        expq1.push_back({(w != 8'h00), w});
            cnt_m[k]  = 0;
            full_m[k] = 1'b1;
        end else if (consume) begin
            full_m[k] = 1'b0;
        end
    endtask

    // Cycle model: sampled mid-cycle, advanced as if the coming edge happens.
    always @(negedge clk) begin
        model_step(0, rdy0, vld0);
        model_step(1, rdy1, vld1);
    end

    // Monitor: score every word the consumer takes.
    always @(negedge clk) begin
        logic [8:0] e;
        if (!reset && vld0 && out_ready) begin
            if (expq0.size() == 0) check("unexpected_word_msb", {23'd0, any0, dat0}, 32'h1ff);
            else begin
                e = expq0.pop_front();
                check("word_msb", {23'd0, any0, dat0}, {23'd0, e});
            end
        end
        if (!reset && vld1 && out_ready) begin
            if (expq1.size() == 0) check("unexpected_word_lsb", {23'd0, any1, dat1}, 32'h1ff);
            else begin
                e = expq1.pop_front();
                check("word_lsb", {23'd0, any1, dat1}, {23'd0, e});
            end
        end
    end

    // Present a bit (entered just after a rising edge) and hold it until accepted.
    task automatic send_bit(input logic b);
        logic acc;
        int   guard;
        acc = 1'b0;
        guard = 0;
        in_valid = 1'b1;
        in_bit = b;
        while (!acc && guard < 64) begin
            @(negedge clk);
            acc = rdy0;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v, input int gap);
        logic [7:0] t;
        t = v;
        for (int i = 7; i >= 0; i--) begin
            send_bit(t[i]);
            repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        logic [7:0] pat;
        reset = 1'b1; in_bit = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_valid", {31'd0, vld0}, 32'd0);
        check("rst_data", {24'd0, dat0}, 32'd0);
        check("rst_any", {31'd0, any0}, 32'd0);
        check("rst_ready", {31'd0, rdy0}, 32'd1);
        @(posedge clk); #1;

        // Alternating pattern, word visible one cycle after the last bit.
        send_byte(8'hAA, 0);
        @(negedge clk);
        check("t1_valid", {31'd0, vld0}, 32'd1);
        check("t1_data_msb", {24'd0, dat0}, 32'h0AA);
        check("t1_data_lsb", {24'd0, dat1}, 32'h055);
        check("t1_any", {31'd0, any0}, 32'd1);
        @(posedge clk); #1;

        send_byte(8'h00, 0);
        @(negedge clk);
        check("t2_data", {24'd0, dat0}, 32'd0);
        check("t2_any", {31'd0, any0}, 32'd0);
        @(posedge clk); #1;

        // Backpressure: second word's last bit stalls until the consumer is ready.
        out_ready = 1'b0;
        send_byte(8'hFF, 0);
        pat = 8'h0F;
        for (int i = 7; i >= 1; i--) send_bit(pat[i]);
        in_valid = 1'b1; in_bit = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t3_stall", {31'd0, rdy0}, 32'd0);
            check("t3_hold", {24'd0, dat0}, 32'h0FF);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("t3_release", {31'd0, rdy0}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("t3_refill_valid", {31'd0, vld0}, 32'd1);
        check("t3_refill_data", {24'd0, dat0}, 32'h00F);
        @(posedge clk); #1;

        // Reset mid-word discards partial bits.
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("t4_valid_after_rst", {31'd0, vld0}, 32'd0);
        @(posedge clk); #1;
        send_byte(8'h01, 0);
        @(negedge clk);
        check("t4_data", {24'd0, dat0}, 32'h001);
        @(posedge clk); #1;

        send_byte(8'hC3, 2);
        send_byte(8'h80, 0);
        send_byte(8'h01, 0);

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            in_valid  = 1'($urandom_range(0, 3) != 0);
            in_bit    = 1'($urandom);
            out_ready = 1'($urandom_range(0, 2) != 0);
            reset     = 1'($urandom_range(0, 199) == 0);
            @(posedge clk); #1;
        end
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        check("drain_msb", expq0.size(), 32'd0);
        check("drain_lsb", expq1.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
